oam_scan_fsm: RTL and testbench

PPU mode‑2 stage: on `start`, walks all 40 OAM entries, selects up to 10 sprites overlapping the current line `LY`, and publishes them as `sprite_queue` with a one‑cycle `done_out` pulse. Sits directly upstream of `mode_3_fsm`, whose fetcher consumes `sprite_queue` during pixel transfer. Reads OAM only, through the shared 0xFE00–0xFE9F bus.

---
 rtl/gb_ppu_pkg.sv | 25 ++
 rtl/sprite_line_match.sv | 22 ++
 rtl/oam_scan_fsm.sv | 184 ++++++++++++++++++
 tb/tb_oam_scan_fsm.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/gb_ppu_pkg.sv
// Shared PPU definitions: OAM geometry, sprite-queue slot layout and scan FSM states.
// Used by oam_scan_fsm (optional build macro OAM_SCAN_EARLY_EXIT_EN lives there).
package gb_ppu_pkg;

  localparam logic [15:0] OAM_BASE    = 16'hFE00;
  localparam int unsigned MAX_SPRITES = 10;
  localparam int unsigned NUM_OAM     = 40;
  localparam int unsigned OAM_BYTES   = NUM_OAM * 4;

  // One sprite-queue slot, MSB first: Y, X, tile, flags, OAM index.
  typedef struct packed {
    logic [7:0] y;
    logic [7:0] x;
    logic [7:0] tile;
    logic [7:0] flags;
    logic [7:0] oam_index;
  } sprite_entry_t;

  typedef enum logic [1:0] {
    StIdle,
    StScan,
    StDone
  } scan_state_e;

endpackage

// File: rtl/sprite_line_match.sv
// Combinational test of whether a sprite with top coordinate Y covers line LY.
// Sprite Y is stored with a +16 bias, so the line is compared as LY+16 in 9 bits (no wrap).
module sprite_line_match (
  input  logic [7:0] ly_i,
  input  logic [7:0] y_i,
  input  logic       tall_i,
  output logic       match_o
);

  logic [8:0] line_biased;
  logic [8:0] top;
  logic [8:0] bottom;

  // Sprite covers biased rows [Y, Y+h) with h = 16 for 8x16 objects, else 8.
  always_comb begin
    line_biased = {1'b0, ly_i} + 9'd16;
    top         = {1'b0, y_i};
    bottom      = top + (tall_i ? 9'd16 : 9'd8);
    match_o     = (line_biased >= top) && (line_biased < bottom);
  end

endmodule

// File: rtl/oam_scan_fsm.sv
// PPU mode-2 OAM scan: reads all 40 OAM entries and keeps up to 10 sprites that overlap the
// latched line. Optional macro OAM_SCAN_EARLY_EXIT_EN stops the scan once 10 sprites are held.
module oam_scan_fsm
  import gb_ppu_pkg::*;
(
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 start,
  output logic                                 done_out,
  input  logic          [7:0]                  oam_dout,
  output logic          [15:0]                 oam_a,
  output logic          [7:0]                  oam_din,
  output logic                                 oam_wr,
  input  logic          [7:0]                  LCDC,
  input  logic          [7:0]                  LY,
  output sprite_entry_t [MAX_SPRITES-1:0]      sprite_queue,
  output logic          [3:0]                  sprite_count,
  output logic          [7:0]                  mode_2_cycles
);

  localparam logic [3:0] MaxCnt   = 4'(MAX_SPRITES);
  localparam logic [7:0] LastByte = 8'(OAM_BYTES - 1);

  scan_state_e state_q, state_d;
  logic [7:0]  ly_q, ly_d;
  logic        obj_en_q, obj_en_d;
  logic        tall_q, tall_d;
  logic [15:0] oam_a_q, oam_a_d;
  logic        iss_q, iss_d;         // an address is being issued this cycle
  logic        rd_vld_q, rd_vld_d;   // oam_dout carries byte rd_idx_q this cycle
  logic [7:0]  rd_idx_q, rd_idx_d;
  logic [7:0]  y_q, y_d;
  logic [7:0]  x_q, x_d;
  logic [7:0]  tile_q, tile_d;
  sprite_entry_t [MAX_SPRITES-1:0] queue_q, queue_d;
  logic [3:0]  count_q, count_d;
  logic [7:0]  cyc_q, cyc_d;

  logic [7:0]  off;
  logic        eval;
  logic        match;
  logic        store;

  sprite_line_match u_match (
    .ly_i   (ly_q),
    .y_i    (y_q),
    .tall_i (tall_q),
    .match_o(match)
  );

  // Entry evaluation happens on the cycle its flags byte (byte 3) comes back.
  always_comb begin
    off   = oam_a_q[7:0];
    eval  = rd_vld_q && (rd_idx_q[1:0] == 2'd3);
    store = eval && match && obj_en_q && (count_q < MaxCnt);
  end

  // Next-state: start restarts from any state; SCAN issues addresses and collects sprites.
  always_comb begin
    state_d  = state_q;
    ly_d     = ly_q;
    obj_en_d = obj_en_q;
    tall_d   = tall_q;
    oam_a_d  = oam_a_q;
    iss_d    = iss_q;
    rd_vld_d = 1'b0;
    rd_idx_d = rd_idx_q;
    y_d      = y_q;
    x_d      = x_q;
    tile_d   = tile_q;
    queue_d  = queue_q;
    count_d  = count_q;
    cyc_d    = cyc_q;

    if (start) begin
      ly_d     = LY;
      obj_en_d = LCDC[1];
      tall_d   = LCDC[2];
      queue_d  = '0;
      count_d  = '0;
      oam_a_d  = OAM_BASE;
      iss_d    = 1'b1;
      cyc_d    = 8'd1;
      state_d  = StScan;
    end else begin
      unique case (state_q)
        StIdle: begin
        end
        StScan: begin
          if (cyc_q != 8'hFF) cyc_d = cyc_q + 8'd1;
          rd_vld_d = iss_q;
          rd_idx_d = off;
          if (iss_q) begin
            if (off == LastByte) iss_d = 1'b0;
            else                 oam_a_d = oam_a_q + 16'd1;
          end
          if (rd_vld_q) begin
            case (rd_idx_q[1:0])
              2'd0:    y_d    = oam_dout;
              2'd1:    x_d    = oam_dout;
              2'd2:    tile_d = oam_dout;
              default: ;
            endcase
          end
          if (store) begin
            queue_d[count_q] = sprite_entry_t'{
              y:         y_q,
              x:         x_q,
              tile:      tile_q,
              flags:     oam_dout,
              oam_index: {2'b00, rd_idx_q[7:2]}
            };
            count_d = count_q + 4'd1;
          end
          if (eval && (rd_idx_q == LastByte)) state_d = StDone;
`ifdef OAM_SCAN_EARLY_EXIT_EN
          // Queue full: stop reading right away and finish one cycle later.
          if (store && (count_q == MaxCnt - 4'd1)) begin
            iss_d   = 1'b0;
            oam_a_d = oam_a_q;
          end
          if (count_q == MaxCnt) begin
            iss_d   = 1'b0;
            state_d = StDone;
          end
`endif
        end
        StDone: begin
          state_d = StIdle;
        end
        default: begin
          state_d = StIdle;
        end
      endcase
    end
  end

  // State registers with synchronous reset; reset beats a coincident start.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      ly_q     <= '0;
      obj_en_q <= 1'b0;
      tall_q   <= 1'b0;
      oam_a_q  <= OAM_BASE;
      iss_q    <= 1'b0;
      rd_vld_q <= 1'b0;
      rd_idx_q <= '0;
      y_q      <= '0;
      x_q      <= '0;
      tile_q   <= '0;
      queue_q  <= '0;
      count_q  <= '0;
      cyc_q    <= '0;
    end else begin
      state_q  <= state_d;
      ly_q     <= ly_d;
      obj_en_q <= obj_en_d;
      tall_q   <= tall_d;
      oam_a_q  <= oam_a_d;
      iss_q    <= iss_d;
      rd_vld_q <= rd_vld_d;
      rd_idx_q <= rd_idx_d;
      y_q      <= y_d;
      x_q      <= x_d;
      tile_q   <= tile_d;
      queue_q  <= queue_d;
      count_q  <= count_d;
      cyc_q    <= cyc_d;
    end
  end

  assign done_out      = (state_q == StDone);
  assign oam_a         = oam_a_q;
  assign oam_din       = 8'h00;
  assign oam_wr        = 1'b0;
  assign sprite_queue  = queue_q;
  assign sprite_count  = count_q;
  assign mode_2_cycles = cyc_q;

  logic unused_lcdc;
  assign unused_lcdc = ^{LCDC[7:3], LCDC[0]};

endmodule

// File: tb/tb_oam_scan_fsm.sv
// Bench for oam_scan_fsm: directed and random OAM contents against a line-match reference model.
module tb_oam_scan_fsm;
  import gb_ppu_pkg::*;

  logic clk = 1'b0;
  logic rst, start, done_out, oam_wr;
  logic [7:0] oam_dout, oam_din, LCDC, LY, mode_2_cycles;
  logic [15:0] oam_a;
  sprite_entry_t [MAX_SPRITES-1:0] sprite_queue;
  logic [3:0] sprite_count;

  logic [7:0]  oam_mem [160];
  logic [39:0] exp_q [10];
  int          exp_cnt;
  int          exp_done;
  int          errors = 0;
  int          checks = 0;

  always #5 clk = ~clk;

  oam_scan_fsm dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .done_out     (done_out),
    .oam_dout     (oam_dout),
    .oam_a        (oam_a),
    .oam_din      (oam_din),
    .oam_wr       (oam_wr),
    .LCDC         (LCDC),
    .LY           (LY),
    .sprite_queue (sprite_queue),
    .sprite_count (sprite_count),
    .mode_2_cycles(mode_2_cycles)
  );

  // OAM with one-cycle read latency.
  always @(posedge clk) begin
    if (oam_a >= 16'hFE00 && oam_a < 16'hFEA0) oam_dout <= oam_mem[int'(oam_a - 16'hFE00)];
    else oam_dout <= 8'hFF;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: walk entries in OAM order, keep the first 10 whose rows cover LY.
  task automatic model(input logic [7:0] ly, input logic [7:0] lcdc);
    int h;
    int n;
    int y;
    int line;
    h = lcdc[2] ? 16 : 8;
    n = 0;
    line = int'(ly) + 16;
    exp_done = 162;
    for (int k = 0; k < 10; k++) exp_q[k] = '0;
    for (int i = 0; i < 40; i++) begin
      y = int'(oam_mem[4*i]);
      if (lcdc[1] && line >= y && line < y + h && n < 10) begin
        exp_q[n] = {oam_mem[4*i], oam_mem[4*i+1], oam_mem[4*i+2], oam_mem[4*i+3], 8'(i)};
        n++;
`ifdef OAM_SCAN_EARLY_EXIT_EN
        if (n == 10) exp_done = 4*i + 5 + 2;
`endif
      end
    end
    exp_cnt = n;
  endtask

  task automatic clear_oam();
    for (int i = 0; i < 160; i++) oam_mem[i] = 8'h00;
  endtask

  // Pulse start for cycle 0; returns in cycle 1. LY/LCDC are scrambled afterwards to prove latching.
  task automatic start_scan(input logic [7:0] ly, input logic [7:0] lcdc);
    LY = ly;
    LCDC = lcdc;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    LY = 8'($urandom);
    LCDC = 8'($urandom);
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_done"}, 64'(done_out), 64'd0);
    chk({tag, "_oam_a"}, 64'(oam_a), 64'hFE00);
    chk({tag, "_count"}, 64'(sprite_count), 64'd0);
    chk({tag, "_queue_nonzero"}, 64'(|sprite_queue), 64'd0);
    chk({tag, "_cycles"}, 64'(mode_2_cycles), 64'd0);
  endtask

  // From cycle 1, wait for done_out and compare everything with the model.
  task automatic finish_scan(input string tag);
    int t;
    bit addr_ok;
    t = 1;
    addr_ok = 1'b1;
    while (!done_out && t < 400) begin
      if (t <= exp_done - 2 && oam_a !== 16'hFE00 + 16'(t - 1)) addr_ok = 1'b0;
      @(posedge clk);
      #1;
      t++;
    end
    chk({tag, "_done_cycle"}, 64'(t), 64'(exp_done));
    chk({tag, "_addr_seq"}, 64'(addr_ok), 64'd1);
    chk({tag, "_count"}, 64'(sprite_count), 64'(exp_cnt));
    for (int k = 0; k < 10; k++)
      chk($sformatf("%s_slot%0d", tag, k), 64'(sprite_queue[k]), 64'(exp_q[k]));
    chk({tag, "_cycles"}, 64'(mode_2_cycles), 64'(exp_done));
    @(posedge clk);
    #1;
    chk({tag, "_pulse_end"}, 64'(done_out), 64'd0);
    chk({tag, "_count_hold"}, 64'(sprite_count), 64'(exp_cnt));
  endtask

  task automatic run_scan(input string tag, input logic [7:0] ly, input logic [7:0] lcdc);
    model(ly, lcdc);
    start_scan(ly, lcdc);
    finish_scan(tag);
  endtask

  task automatic fill_fifteen();
    clear_oam();
    for (int i = 0; i < 15; i++) begin
      oam_mem[4*i]   = 8'd16;
      oam_mem[4*i+1] = 8'(8 * i);
      oam_mem[4*i+2] = 8'(i + 100);
      oam_mem[4*i+3] = 8'(i ^ 8'h5A);
    end
  endtask

  task automatic fill_plan1();
    clear_oam();
    oam_mem[12] = 8'd16; oam_mem[13] = 8'd40;  oam_mem[14] = 8'h21; oam_mem[15] = 8'h80;
    oam_mem[28] = 8'd9;  oam_mem[29] = 8'd170; oam_mem[30] = 8'h33; oam_mem[31] = 8'h10;
  endtask

  initial begin
    int ly_r;
    bit no_pulse;
    rst = 1'b1;
    start = 1'b0;
    LY = 8'd0;
    LCDC = 8'd0;
    clear_oam();
    repeat (3) @(posedge clk);
    #1;
    check_reset("reset");
    chk("reset_oam_wr", 64'(oam_wr), 64'd0);
    chk("reset_oam_din", 64'(oam_din), 64'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Two sprites, one partially above the line; X=170 still kept.
    fill_plan1();
    run_scan("plan1", 8'd0, 8'h02);
    chk("plan1_slot0_idx", 64'(sprite_queue[0].oam_index), 64'd3);
    chk("plan1_slot1_idx", 64'(sprite_queue[1].oam_index), 64'd7);

    // Tall vs short objects for Y=12 at LY=10.
    clear_oam();
    oam_mem[20] = 8'd12; oam_mem[21] = 8'd0; oam_mem[22] = 8'h44; oam_mem[23] = 8'h20;
    run_scan("tall", 8'd10, 8'h06);
    chk("tall_count_const", 64'(sprite_count), 64'd1);
    run_scan("short", 8'd10, 8'h02);
    chk("short_count_const", 64'(sprite_count), 64'd0);

    // Overflow: 15 candidates, only 10 kept.
    fill_fifteen();
    run_scan("full", 8'd5, 8'h02);
    chk("full_slot9_idx", 64'(sprite_queue[9].oam_index), 64'd9);

    // Objects disabled.
    run_scan("objoff", 8'd5, 8'h04);

    // Restart mid-scan at cycle 50.
    fill_plan1();
    start_scan(8'd0, 8'h02);
    repeat (49) begin
      @(posedge clk);
      #1;
    end
    fill_fifteen();
    model(8'd5, 8'h02);
    start_scan(8'd5, 8'h02);
    chk("restart_oam_a", 64'(oam_a), 64'hFE00);
    chk("restart_count", 64'(sprite_count), 64'd0);
    chk("restart_queue_nonzero", 64'(|sprite_queue), 64'd0);
    finish_scan("restart");

    // Reset at cycle 80 aborts the scan without a done pulse.
    fill_plan1();
    start_scan(8'd0, 8'h02);
    repeat (79) begin
      @(posedge clk);
      #1;
    end
    rst = 1'b1;
    start = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    start = 1'b0;
    check_reset("midrst");
    no_pulse = 1'b1;
    repeat (200) begin
      if (done_out) no_pulse = 1'b0;
      @(posedge clk);
      #1;
    end
    chk("midrst_no_done", 64'(no_pulse), 64'd1);
    chk("midrst_oam_a_hold", 64'(oam_a), 64'hFE00);

    // Random OAM contents clustered around the line.
    for (int r = 0; r < 6; r++) begin
      ly_r = int'($urandom_range(0, 143));
      for (int i = 0; i < 40; i++) begin
        oam_mem[4*i]   = 8'(ly_r + int'($urandom_range(0, 34)));
        oam_mem[4*i+1] = ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom);
        oam_mem[4*i+2] = 8'($urandom);
        oam_mem[4*i+3] = 8'($urandom);
      end
      run_scan($sformatf("rand%0d", r), 8'(ly_r),
               {5'($urandom), 1'($urandom), ($urandom_range(0, 4) != 0), 1'($urandom)});
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
